// File: rtl/dw_ram_nr_w_s_dff.sv
// Multi-read-port flop RAM with byte-enabled writes.
// Optional registered reads with write-through or read-old on collision.
module dw_ram_nr_w_s_dff #(
  parameter int data_width   = 16,
  parameter int depth        = 16,
  parameter int num_rd_ports = 2,
  parameter int rst_mode     = 0,
  parameter int rd_latency   = 1,
  parameter int bypass_mode  = 1,
  localparam int aw = $clog2(depth),
  localparam int bw = (data_width + 7) / 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cs_n,
  input  logic                               wr_n,
  input  logic [aw-1:0]                      wr_addr,
  input  logic [bw-1:0]                      be,
  input  logic [data_width-1:0]              data_in,
  input  logic [num_rd_ports-1:0]            rd_en,
  input  logic [num_rd_ports*aw-1:0]         rd_addr,
  output logic [num_rd_ports*data_width-1:0] data_out
);

  localparam logic [aw:0] depth_v = (aw + 1)'(depth);

  logic [data_width-1:0] mem [depth];
  logic [data_width-1:0] wmask;
  logic [data_width-1:0] wr_merge;
  logic                  wr_ok;
  logic                  we;

  always_comb begin
    wmask = '0;
    for (int i = 0; i < data_width; i++)
      wmask[i] = be[i/8];
  end

  assign wr_ok    = {1'b0, wr_addr} < depth_v;
  assign we       = ~cs_n & ~wr_n & wr_ok & (|be);
  assign wr_merge = (data_in & wmask) | (mem[wr_addr] & ~wmask);

  generate
    if (rst_mode == 0) begin : g_arr_rst
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < depth; i++)
            mem[i] <= '0;
        end else if (we) begin
          mem[wr_addr] <= wr_merge;
        end
      end
    end else begin : g_arr_norst
      // Array keeps its contents; a write on a reset edge is still dropped.
      always_ff @(posedge clk) begin
        if (rst_n && we)
          mem[wr_addr] <= wr_merge;
      end
    end
  endgenerate

  generate
    for (genvar p = 0; p < num_rd_ports; p++) begin : g_port
      logic [aw-1:0]         raddr;
      logic                  rd_ok;
      logic [data_width-1:0] arr_word;

      assign raddr    = rd_addr[p*aw +: aw];
      assign rd_ok    = {1'b0, raddr} < depth_v;
      assign arr_word = rd_ok ? mem[raddr] : '0;

      if (rd_latency == 0) begin : g_comb
        assign data_out[p*data_width +: data_width] = arr_word;
      end else begin : g_reg
        logic                  hit;
        logic [data_width-1:0] ld_word;
        logic [data_width-1:0] q;

        assign hit     = (bypass_mode == 1) && we && (wr_addr == raddr);
        assign ld_word = hit ? wr_merge : arr_word;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)
            q <= '0;
          else if (!cs_n && rd_en[p])
            q <= ld_word;
        end

        assign data_out[p*data_width +: data_width] = q;
      end
    end

    if (rd_latency == 0) begin : g_unused
      logic unused_rd_en;
      assign unused_rd_en = ^rd_en;
    end
  endgenerate

endmodule

// File: doc/dw_ram_nr_w_s_dff.md
DW_RAM_NR_W_S_DFF -- requirements
Module: dw_ram_nr_w_s_dff

Interface
REQ-001 SHALL have parameter data_width, default 16, word width in bits, legal 1-256.
REQ-002 SHALL have parameter depth, default 16, number of words, legal 2-256.
REQ-003 SHALL have parameter num_rd_ports, default 2, independent read ports, legal 1-4.
REQ-004 SHALL have parameter rst_mode, default 0; 0 = reset clears array and output registers, 1 = reset clears output registers only.
REQ-005 SHALL have parameter rd_latency, default 1; 0 = combinational read, 1 = registered read.
REQ-006 SHALL have parameter bypass_mode, default 1; 0 = read-old on collision, 1 = write-through on collision (rd_latency=1 only).
REQ-007 SHALL derive localparams aw = ceil(log2(depth)) and bw = ceil(data_width/8).
REQ-008 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-009 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-010 SHALL have port cs_n  input  1  chip select, active-low; high blocks writes and output-register loads.
REQ-011 SHALL have port wr_n  input  1  write enable, active-low.
REQ-012 SHALL have port wr_addr  input  aw  write address.
REQ-013 SHALL have port be  input  bw  byte enables, bit i covers data bits [8i+7:8i] (top byte truncated).
REQ-014 SHALL have port data_in  input  data_width  write data.
REQ-015 SHALL have port rd_en  input  num_rd_ports  per-port read enable (used when rd_latency=1).
REQ-016 SHALL have port rd_addr  input  num_rd_ports*aw  read addresses, port p at [p*aw +: aw].
REQ-017 SHALL have port data_out  output  num_rd_ports*data_width  read data, port p at [p*data_width +: data_width].

Function
REQ-018 SHALL write on rising clk when cs_n=0, wr_n=0, rst_n=1: each byte with be[i]=1 updated from data_in; others held.
REQ-019 SHALL ignore writes with wr_addr >= depth; array unchanged.
REQ-020 SHALL, for rd_latency=0, drive each port combinationally from array[rd_addr]; new write data visible only after the write edge.
REQ-021 SHALL, for rd_latency=1, load port p output register on rising clk when cs_n=0 and rd_en[p]=1; otherwise hold.
REQ-022 SHALL return 0 on any port whose rd_addr >= depth.
REQ-023 SHALL, for rd_latency=1 and bypass_mode=1, on same-edge write/read to same valid address, load merged word: enabled bytes from data_in, others from array.
REQ-024 SHALL, for rd_latency=1 and bypass_mode=0, load pre-write array contents on collision.
REQ-025 SHALL allow all read ports to address the same word simultaneously with identical results.
REQ-026 SHALL treat be=0 with write asserted as no write, including no bypass merge change.
REQ-027 SHALL treat X-free outputs as required after reset for rst_mode=0; for rst_mode=1 array contents undefined until written.

Reset
REQ-028 SHALL, on rst_n=0, immediately (asynchronously) clear all output registers to 0 (rd_latency=1).
REQ-029 SHALL, for rst_mode=0, asynchronously clear every array word to 0; rst_mode=1 leaves array untouched.
REQ-030 SHALL suppress any write whose edge coincides with rst_n=0; reset asserted mid-operation wins over write and read load.
REQ-031 SHALL resume normal operation on the first rising clk after rst_n deasserts.

Verification
REQ-032 Reset: defaults, write 0xA5A5 to addr 3, assert rst_n=0 between edges -> data_out=0 at once; read addr 3 after release -> 0x0000.
REQ-033 Byte enable: write 0x1234 addr 5 be=11, then 0xABCD be=01 -> read addr 5 returns 0x12CD.
REQ-034 Collision: addr 7 holds 0x0000; same edge write 0xBEEF be=11 and read addr 7 port 0 -> 0xBEEF (bypass_mode=1), 0x0000 (bypass_mode=0).
REQ-035 Multi-port: port 0 addr 2, port 1 addr 9 with 0x1111/0x2222 stored -> data_out = {0x2222,0x1111} one cycle after rd_en=11.
REQ-036 Range/hold: depth=12, write addr 13 ignored, read addr 14 -> 0; rd_en=0 or cs_n=1 -> data_out holds prior value.
REQ-037 Latency 0: rd_latency=0, write 0x5555 addr 1 -> data_out old value before edge, 0x5555 same cycle after edge.
